// File: rtl/sarray_mem_resp_if.sv
// sarray load/store channels (ar/r/aw) between sarray_top and the memory responder.
// Each channel uses valid/ready; aw carries address and data in a single beat.
interface sarray_mem_resp_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 512
);
    logic              ar_valid;
    logic              ar_ready;
    logic [ADDR_W-1:0] ar_addr;
    logic              r_valid;
    logic              r_ready;
    logic [DATA_W-1:0] r_data;
    logic              aw_valid;
    logic              aw_ready;
    logic [ADDR_W-1:0] aw_addr;
    logic [DATA_W-1:0] aw_data;

    modport slave (
        input  ar_valid, ar_addr, r_ready, aw_valid, aw_addr, aw_data,
        output ar_ready, r_valid, r_data, aw_ready
    );

    modport master (
        output ar_valid, ar_addr, r_ready, aw_valid, aw_addr, aw_data,
        input  ar_ready, r_valid, r_data, aw_ready
    );
endinterface

// File: rtl/sarray_mem_resp.sv
// Scratchpad responder for sarray loads/stores: reads return in order RD_LAT cycles after accept,
// writes land at the accept edge; ar is credit-limited to OUTQ_DEPTH outstanding and yields to aw.
module sarray_mem_resp #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 512,
    parameter int DEPTH      = 256,
    parameter int RD_LAT     = 2,
    parameter int OUTQ_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    sarray_mem_resp_if.slave    sarray,
    output logic [31:0]         rd_cnt_o,
    output logic [31:0]         wr_cnt_o
);
    localparam int LSB   = $clog2(DATA_W / 8);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = $clog2(OUTQ_DEPTH);
    localparam int QP_W  = PTR_W + 1;

    logic [IDX_W-1:0]  ar_idx, aw_idx;
    logic              ar_fire, aw_fire, pop;
    logic              push_vld;
    logic [DATA_W-1:0] push_dat, rd_word;
    logic              q_empty;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] q_dat_q [OUTQ_DEPTH];
    logic [QP_W-1:0]   wp_q, wp_d, rp_q, rp_d, out_cnt_q, out_cnt_d;
    logic [31:0]       rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

    logic unused_addr;
    assign unused_addr = ^{sarray.ar_addr, sarray.aw_addr};

    assign ar_idx  = sarray.ar_addr[LSB +: IDX_W];
    assign aw_idx  = sarray.aw_addr[LSB +: IDX_W];

    // Writes win the single array port; outstanding is registered so a pop frees a credit one cycle later.
    assign sarray.aw_ready = 1'b1;
    assign sarray.ar_ready = !sarray.aw_valid && (out_cnt_q < QP_W'(OUTQ_DEPTH));
    assign aw_fire = sarray.aw_valid;
    assign ar_fire = sarray.ar_valid && sarray.ar_ready;

    assign q_empty        = (wp_q == rp_q);
    assign sarray.r_valid = !q_empty;
    assign sarray.r_data  = q_empty ? '0 : q_dat_q[rp_q[PTR_W-1:0]];
    assign pop            = sarray.r_valid && sarray.r_ready;

    assign rd_word  = mem_q[ar_idx];
    assign rd_cnt_o = rd_cnt_q;
    assign wr_cnt_o = wr_cnt_q;

    always_ff @(posedge clk) begin
        if (aw_fire) mem_q[aw_idx] <= sarray.aw_data;
    end

    // The array is sampled at the accept edge, so later writes never leak into an in-flight read.
    generate
        if (RD_LAT == 1) begin : g_lat1
            assign push_vld = ar_fire;
            assign push_dat = rd_word;
        end else begin : g_pipe
            localparam int NS = RD_LAT - 1;
            logic [NS-1:0]     pv_q, pv_d;
            logic [DATA_W-1:0] pd_q [NS];
            logic [DATA_W-1:0] pd_d [NS];

            always_comb begin
                pv_d    = pv_q;
                pd_d    = pd_q;
                pv_d[0] = ar_fire;
                pd_d[0] = rd_word;
                for (int i = 1; i < NS; i++) begin
                    pv_d[i] = pv_q[i-1];
                    pd_d[i] = pd_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) pv_q <= '0;
                else        pv_q <= pv_d;
            end

            always_ff @(posedge clk) begin
                pd_q <= pd_d;
            end

            assign push_vld = pv_q[NS-1];
            assign push_dat = pd_q[NS-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push_vld) q_dat_q[wp_q[PTR_W-1:0]] <= push_dat;
    end

    always_comb begin
        wp_d      = wp_q + QP_W'(push_vld);
        rp_d      = rp_q + QP_W'(pop);
        out_cnt_d = out_cnt_q + QP_W'(ar_fire) - QP_W'(pop);
        rd_cnt_d  = rd_cnt_q + 32'(ar_fire);
        wr_cnt_d  = wr_cnt_q + 32'(aw_fire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q      <= '0;
            rp_q      <= '0;
            out_cnt_q <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
        end else begin
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            out_cnt_q <= out_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end
endmodule

// File: tb/tb_sarray_mem_resp.sv
// Randomized bench for sarray_mem_resp against a queue-based model of outstanding reads.
module tb_sarray_mem_resp;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 512;
    localparam int DEPTH  = 256;
    localparam int RD_LAT = 2;
    localparam int OUTQ   = 4;
    localparam int BYTES  = DATA_W / 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rd_cnt, wr_cnt;

    always #5 clk = ~clk;

    sarray_mem_resp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sif ();

    sarray_mem_resp #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .OUTQ_DEPTH(OUTQ)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sarray   (sif.slave),
        .rd_cnt_o (rd_cnt),
        .wr_cnt_o (wr_cnt)
    );

    typedef struct {
        logic [DATA_W-1:0] dat;
        int                rdy;
    } rd_t;

    logic [DATA_W-1:0] ref_mem [DEPTH];
    rd_t               pend [$];
    int                edges = 0;
    logic [31:0]       exp_rd = 0, exp_wr = 0;
    bit                last_ar_acc = 0;
    int                vectors = 0, miscompares = 0;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic int word_of(input logic [ADDR_W-1:0] a);
        return int'((a / BYTES) % DEPTH);
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr(input int idx);
        return ADDR_W'(idx * BYTES + $urandom_range(0, BYTES - 1)
                       + $urandom_range(0, 15) * DEPTH * BYTES);
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d = '0;
        for (int i = 0; i < DATA_W / 32; i++) d = {d[DATA_W-33:0], 32'($urandom)};
        return d;
    endfunction

    // Check outputs mid-cycle, then advance the model by the upcoming posedge.
    task automatic cycle();
        bit  exp_arr, exp_rv, aw_f, ar_f, pop;
        rd_t e;
        #1;
        exp_arr = !sif.aw_valid && (pend.size() < OUTQ);
        exp_rv  = (pend.size() > 0) && (pend[0].rdy <= edges);
        chk("ar_ready", DATA_W'(sif.ar_ready), DATA_W'(exp_arr));
        chk("aw_ready", DATA_W'(sif.aw_ready), DATA_W'(1));
        chk("r_valid",  DATA_W'(sif.r_valid),  DATA_W'(exp_rv));
        if (exp_rv) chk("r_data", sif.r_data, pend[0].dat);
        chk("rd_cnt", DATA_W'(rd_cnt), DATA_W'(exp_rd));
        chk("wr_cnt", DATA_W'(wr_cnt), DATA_W'(exp_wr));
        aw_f = sif.aw_valid;
        ar_f = sif.ar_valid && exp_arr;
        pop  = exp_rv && sif.r_ready;
        @(posedge clk);
        edges++;
        if (pop) void'(pend.pop_front());
        if (aw_f) begin
            ref_mem[word_of(sif.aw_addr)] = sif.aw_data;
            exp_wr++;
        end
        if (ar_f) begin
            e.dat = ref_mem[word_of(sif.ar_addr)];
            e.rdy = edges + RD_LAT - 1;
            pend.push_back(e);
            exp_rd++;
        end
        last_ar_acc = ar_f;
        @(negedge clk);
    endtask

    // A pending ar holds its address until accepted; hot words make write/read collisions common.
    task automatic drive_rand(input int p_ar, input int p_aw, input int p_rr);
        if (!sif.ar_valid || last_ar_acc) begin
            sif.ar_valid = ($urandom_range(0, 99) < p_ar);
            sif.ar_addr  = rand_addr(($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1)
                                                                 : $urandom_range(0, 7));
        end
        sif.aw_valid = ($urandom_range(0, 99) < p_aw);
        sif.aw_addr  = rand_addr(($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1)
                                                             : $urandom_range(0, 7));
        sif.aw_data  = rand_data();
        sif.r_ready  = ($urandom_range(0, 99) < p_rr);
    endtask

    task automatic reset_check(input string tag);
        sif.ar_valid = 1'b0;
        sif.aw_valid = 1'b0;
        sif.r_ready  = 1'b0;
        rst_n = 1'b0;
        pend.delete();
        exp_rd = 0;
        exp_wr = 0;
        last_ar_acc = 0;
        #1;
        chk({tag, "_r_valid"},  DATA_W'(sif.r_valid),  DATA_W'(0));
        chk({tag, "_r_data"},   sif.r_data,            '0);
        chk({tag, "_ar_ready"}, DATA_W'(sif.ar_ready), DATA_W'(1));
        chk({tag, "_aw_ready"}, DATA_W'(sif.aw_ready), DATA_W'(1));
        chk({tag, "_rd_cnt"},   DATA_W'(rd_cnt),       DATA_W'(0));
        chk({tag, "_wr_cnt"},   DATA_W'(wr_cnt),       DATA_W'(0));
        @(negedge clk);
        edges++;
        rst_n = 1'b1;
    endtask

    initial begin
        sif.ar_valid = 1'b0;
        sif.ar_addr  = '0;
        sif.aw_valid = 1'b0;
        sif.aw_addr  = '0;
        sif.aw_data  = '0;
        sif.r_ready  = 1'b0;
        rst_n        = 1'b0;
        @(negedge clk);
        reset_check("por");

        for (int i = 0; i < DEPTH; i++) begin
            sif.aw_valid = 1'b1;
            sif.aw_addr  = rand_addr(i);
            sif.aw_data  = rand_data();
            cycle();
        end
        sif.aw_valid = 1'b0;

        for (int i = 0; i < 40; i++) begin drive_rand(100, 0, 100); cycle(); end
        for (int i = 0; i < 12; i++) begin drive_rand(100, 0, 0);   cycle(); end
        for (int i = 0; i < 12; i++) begin drive_rand(100, 0, 100); cycle(); end
        for (int i = 0; i < 600; i++) begin drive_rand(70, 30, 60); cycle(); end

        for (int i = 0; i < 3; i++) begin drive_rand(100, 0, 0); cycle(); end
        reset_check("mid_rst");
        for (int i = 0; i < 6; i++) begin drive_rand(0, 0, 100); cycle(); end
        for (int i = 0; i < 300; i++) begin drive_rand(70, 30, 60); cycle(); end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
